lsu_stage: RTL and testbench

Parametrised pipeline memory stage for the RV32 core, sitting between execute and writeback. It performs byte/halfword/word loads and stores with lane steering, sign/zero extension and misalignment detection. It drives the data RAM through a wait-state FSM whose latency is a parameter, holds the pipeline with `stall_o` until the access completes, and also resolves branch/jump redirects and writeback source selection.

---
 rtl/lsu_stage_if.sv | 24 ++
 rtl/lsu_stage.sv | 182 ++++++++++++++++++
 tb/tb_lsu_stage.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_stage_if.sv
// Port-B bus between the memory stage (master) and the data RAM (slave).
interface ram_interface;
  logic        en_i_b;
  logic [3:0]  we_i_b;
  logic [31:0] addr_i_b;
  logic [31:0] data_i_b;
  logic [31:0] data_o_b;

  modport master (
    output en_i_b,
    output we_i_b,
    output addr_i_b,
    output data_i_b,
    input  data_o_b
  );

  modport slave (
    input  en_i_b,
    input  we_i_b,
    input  addr_i_b,
    input  data_i_b,
    output data_o_b
  );
endinterface

// File: rtl/lsu_stage.sv
// RV32 memory stage: lane-steered loads/stores with a wait-state FSM for a
// fixed-latency data RAM, plus redirect and writeback source selection.
module lsu_stage #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic [4:0]  rd_i,
  input  logic        alu_zero_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] pc_4_i,
  input  logic [31:0] pc_imm_i,
  input  logic        memread_en_i,
  input  logic        memwrite_en_i,
  input  logic [2:0]  mem_size_i,
  input  logic        branch_i,
  input  logic        jmp_i,
  input  logic        wb_en_i,
  input  logic [1:0]  wb_src_i,
  input  logic [1:0]  wb_pc_src_i,
  output logic [4:0]  rd_o,
  output logic        wb_en_o,
  output logic [31:0] wb_value_o,
  output logic [31:0] next_pc_o,
  output logic        branch_taken_o,
  output logic        stall_o,
  output logic        misaligned_o,
  ram_interface.master ram_if
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mem_op;
  logic        misaligned;
  logic        access;
  logic        stall;
  logic        issue;
  logic [1:0]  sz;
  logic [1:0]  lane;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;
  logic [31:0] ld_data;

  assign mem_op    = memread_en_i | memwrite_en_i;
  assign sz        = mem_size_i[1:0];
  assign lane      = alu_result_i[1:0];
  assign ld_signed = ~mem_size_i[2];

  always_comb begin
    misaligned = 1'b0;
    case (sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      default: misaligned = |lane;
    endcase
  end

  assign access = mem_op & ~misaligned;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall = 1'b1;
          issue = 1'b1;
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Reset also masks the combinational handshake outputs, not just the state.
    if (rst) begin
      state_d = IDLE;
      cnt_d   = '0;
      stall   = 1'b0;
      issue   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    st_mask = 4'b1111;
    st_data = rs2_data_i;
    case (sz)
      2'b00: begin
        st_mask = 4'b0001 << lane;
        st_data = {4{rs2_data_i[7:0]}};
      end
      2'b01: begin
        st_mask = alu_result_i[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_data_i[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = rs2_data_i;
      end
    endcase
  end

  always_comb begin
    ld_byte = ram_if.data_o_b[7:0];
    case (lane)
      2'd0: ld_byte = ram_if.data_o_b[7:0];
      2'd1: ld_byte = ram_if.data_o_b[15:8];
      2'd2: ld_byte = ram_if.data_o_b[23:16];
      2'd3: ld_byte = ram_if.data_o_b[31:24];
      default: ld_byte = ram_if.data_o_b[7:0];
    endcase
    ld_half = alu_result_i[1] ? ram_if.data_o_b[31:16] : ram_if.data_o_b[15:0];
    case (sz)
      2'b00:   ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data = ram_if.data_o_b;
    endcase
  end

  always_comb begin
    wb_value_o = '0;
    case (wb_src_i)
      2'd0: wb_value_o = '0;
      2'd1: wb_value_o = alu_result_i;
      2'd2: wb_value_o = pc_4_i;
      2'd3: wb_value_o = ld_data;
      default: wb_value_o = '0;
    endcase
  end

  always_comb begin
    next_pc_o = '0;
    case (wb_pc_src_i)
      2'd0: next_pc_o = '0;
      2'd1: next_pc_o = alu_result_i;
      2'd2: next_pc_o = pc_4_i;
      2'd3: next_pc_o = pc_imm_i;
      default: next_pc_o = '0;
    endcase
  end

  assign rd_o           = rd_i;
  assign branch_taken_o = jmp_i | (branch_i & ~alu_zero_i);
  assign misaligned_o   = mem_op & misaligned & ~rst;
  assign stall_o        = stall;
  assign wb_en_o        = wb_en_i & ~stall & ~misaligned_o & ~rst;

  assign ram_if.en_i_b   = ~rst;
  assign ram_if.we_i_b   = (issue & memwrite_en_i) ? st_mask : '0;
  assign ram_if.addr_i_b = {alu_result_i[31:2], 2'b00};
  assign ram_if.data_i_b = st_data;

endmodule

// File: tb/tb_lsu_stage.sv
// Randomized bench for lsu_stage at LATENCY=1 and LATENCY=4 against a
// byte-addressed memory model and per-instruction cycle expectations.
module tb_lsu_stage;
  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 4;

  typedef struct {
    bit          rd_en;
    bit          wr_en;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc4;
    logic [31:0] pcimm;
    bit          br;
    bit          jmp;
    bit          zero;
    bit          wben;
    logic [1:0]  src;
    logic [1:0]  pcsrc;
    logic [4:0]  rd;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s    [2];
  logic [4:0]  rd_s     [2];
  logic        zero_s   [2];
  logic [31:0] alu_s    [2];
  logic [31:0] rs2_s    [2];
  logic [31:0] pc4_s    [2];
  logic [31:0] pcimm_s  [2];
  logic        mrd_s    [2];
  logic        mwr_s    [2];
  logic [2:0]  size_s   [2];
  logic        br_s     [2];
  logic        jmp_s    [2];
  logic        wben_s   [2];
  logic [1:0]  src_s    [2];
  logic [1:0]  pcsrc_s  [2];

  logic [4:0]  o_rd     [2];
  logic        o_wben   [2];
  logic [31:0] o_wbval  [2];
  logic [31:0] o_npc    [2];
  logic        o_bt     [2];
  logic        o_stall  [2];
  logic        o_mis    [2];
  logic        o_en     [2];
  logic [3:0]  o_we     [2];
  logic [31:0] o_addr   [2];
  logic [31:0] o_wdata  [2];

  logic [31:0] ram0 [128];
  logic [31:0] ram1 [128];
  logic [31:0] rdata0, rdata1;
  logic [7:0]  ref_b [2][512];

  int n_cmp = 0;
  int n_bad = 0;

  ram_interface bus0 ();
  ram_interface bus1 ();

  lsu_stage #(.LATENCY(LAT0)) dut0 (
    .clk_i(clk), .rst(rst_s[0]), .rd_i(rd_s[0]), .alu_zero_i(zero_s[0]),
    .alu_result_i(alu_s[0]), .rs2_data_i(rs2_s[0]), .pc_4_i(pc4_s[0]),
    .pc_imm_i(pcimm_s[0]), .memread_en_i(mrd_s[0]), .memwrite_en_i(mwr_s[0]),
    .mem_size_i(size_s[0]), .branch_i(br_s[0]), .jmp_i(jmp_s[0]),
    .wb_en_i(wben_s[0]), .wb_src_i(src_s[0]), .wb_pc_src_i(pcsrc_s[0]),
    .rd_o(o_rd[0]), .wb_en_o(o_wben[0]), .wb_value_o(o_wbval[0]),
    .next_pc_o(o_npc[0]), .branch_taken_o(o_bt[0]), .stall_o(o_stall[0]),
    .misaligned_o(o_mis[0]), .ram_if(bus0)
  );

  lsu_stage #(.LATENCY(LAT1)) dut1 (
    .clk_i(clk), .rst(rst_s[1]), .rd_i(rd_s[1]), .alu_zero_i(zero_s[1]),
    .alu_result_i(alu_s[1]), .rs2_data_i(rs2_s[1]), .pc_4_i(pc4_s[1]),
    .pc_imm_i(pcimm_s[1]), .memread_en_i(mrd_s[1]), .memwrite_en_i(mwr_s[1]),
    .mem_size_i(size_s[1]), .branch_i(br_s[1]), .jmp_i(jmp_s[1]),
    .wb_en_i(wben_s[1]), .wb_src_i(src_s[1]), .wb_pc_src_i(pcsrc_s[1]),
    .rd_o(o_rd[1]), .wb_en_o(o_wben[1]), .wb_value_o(o_wbval[1]),
    .next_pc_o(o_npc[1]), .branch_taken_o(o_bt[1]), .stall_o(o_stall[1]),
    .misaligned_o(o_mis[1]), .ram_if(bus1)
  );

  assign o_en[0]    = bus0.en_i_b;
  assign o_we[0]    = bus0.we_i_b;
  assign o_addr[0]  = bus0.addr_i_b;
  assign o_wdata[0] = bus0.data_i_b;
  assign bus0.data_o_b = rdata0;
  assign o_en[1]    = bus1.en_i_b;
  assign o_we[1]    = bus1.we_i_b;
  assign o_addr[1]  = bus1.addr_i_b;
  assign o_wdata[1] = bus1.data_i_b;
  assign bus1.data_o_b = rdata1;

  // Synchronous RAMs with byte enables; one-cycle registered read.
  always @(posedge clk) begin
    if (rst_s[0]) begin
      for (int i = 0; i < 128; i++) ram0[i] <= '0;
      rdata0 <= '0;
    end else if (bus0.en_i_b) begin
      for (int b = 0; b < 4; b++)
        if (bus0.we_i_b[b]) ram0[bus0.addr_i_b[8:2]][8*b +: 8] <= bus0.data_i_b[8*b +: 8];
      rdata0 <= ram0[bus0.addr_i_b[8:2]];
    end
  end

  always @(posedge clk) begin
    if (rst_s[1]) begin
      for (int i = 0; i < 128; i++) ram1[i] <= '0;
      rdata1 <= '0;
    end else if (bus1.en_i_b) begin
      for (int b = 0; b < 4; b++)
        if (bus1.we_i_b[b]) ram1[bus1.addr_i_b[8:2]][8*b +: 8] <= bus1.data_i_b[8*b +: 8];
      rdata1 <= ram1[bus1.addr_i_b[8:2]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] size);
    if (size[1:0] == 2'b00) return 1;
    if (size[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit mis_f(input op_t o);
    return (o.rd_en || o.wr_en) && ((o.addr % nbytes(o.size)) != 0);
  endfunction

  function automatic logic [31:0] load_f(input int d, input op_t o);
    int n;
    logic [31:0] v;
    n = nbytes(o.size);
    v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_b[d][(o.addr + k) % 512]) << (8 * k));
    if (!o.size[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  function automatic logic [3:0] mask_f(input op_t o);
    logic [3:0] m;
    m = '0;
    for (int k = 0; k < nbytes(o.size); k++) m[(o.addr % 4) + k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] wdata_f(input op_t o);
    logic [31:0] w;
    int n;
    n = nbytes(o.size);
    for (int j = 0; j < 4; j++) w[8*j +: 8] = o.data[8*(j % n) +: 8];
    return w;
  endfunction

  task automatic drive(input int d, input op_t o);
    rd_s[d] = o.rd;       zero_s[d] = o.zero;   alu_s[d] = o.addr;
    rs2_s[d] = o.data;    pc4_s[d] = o.pc4;     pcimm_s[d] = o.pcimm;
    mrd_s[d] = o.rd_en;   mwr_s[d] = o.wr_en;   size_s[d] = o.size;
    br_s[d] = o.br;       jmp_s[d] = o.jmp;     wben_s[d] = o.wben;
    src_s[d] = o.src;     pcsrc_s[d] = o.pcsrc;
  endtask

  // Called just after a rising edge; returns just after the edge that retires the op.
  task automatic run_op(input int d, input op_t o);
    bit mem, mis, last;
    int ncyc;
    logic [31:0] ev, epc;
    mem  = o.rd_en || o.wr_en;
    mis  = mis_f(o);
    ncyc = (mem && !mis) ? ((d == 0) ? int'(LAT0) : int'(LAT1)) + 1 : 1;
    case (o.src)
      2'd0: ev = '0;
      2'd1: ev = o.addr;
      2'd2: ev = o.pc4;
      default: ev = load_f(d, o);
    endcase
    case (o.pcsrc)
      2'd0: epc = '0;
      2'd1: epc = o.addr;
      2'd2: epc = o.pc4;
      default: epc = o.pcimm;
    endcase
    drive(d, o);
    for (int c = 0; c < ncyc; c++) begin
      last = (c == ncyc - 1);
      @(negedge clk);
      check_eq($sformatf("d%0d c%0d stall", d, c), 32'(o_stall[d]), 32'(!last));
      check_eq($sformatf("d%0d c%0d misaligned", d, c), 32'(o_mis[d]), 32'(mis));
      check_eq($sformatf("d%0d c%0d we", d, c), 32'(o_we[d]),
               (c == 0 && o.wr_en && !mis) ? 32'(mask_f(o)) : 32'd0);
      check_eq($sformatf("d%0d c%0d wb_en", d, c), 32'(o_wben[d]),
               32'(last && !mis && o.wben));
      check_eq($sformatf("d%0d c%0d branch_taken", d, c), 32'(o_bt[d]),
               32'(o.jmp || (o.br && !o.zero)));
      check_eq($sformatf("d%0d c%0d next_pc", d, c), o_npc[d], epc);
      if (c == 0 && o.wr_en && !mis)
        check_eq($sformatf("d%0d store data", d), o_wdata[d], wdata_f(o));
      if (last) begin
        check_eq($sformatf("d%0d en", d), 32'(o_en[d]), 32'd1);
        check_eq($sformatf("d%0d rd", d), 32'(o_rd[d]), 32'(o.rd));
        if (mem) check_eq($sformatf("d%0d addr", d), o_addr[d], {o.addr[31:2], 2'b00});
        if (o.src != 2'd3 || (o.rd_en && !mis))
          check_eq($sformatf("d%0d wb_value", d), o_wbval[d], ev);
      end
      @(posedge clk);
      #1;
    end
    if (o.wr_en && !mis)
      for (int k = 0; k < nbytes(o.size); k++) ref_b[d][o.addr + k] = o.data[8*k +: 8];
  endtask

  function automatic op_t mk(input bit rd_en, input bit wr_en, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] data);
    op_t o;
    o.rd_en = rd_en; o.wr_en = wr_en; o.size = size; o.addr = addr; o.data = data;
    o.pc4 = 32'h0000_1004; o.pcimm = 32'h0000_2000; o.br = 1'b0; o.jmp = 1'b0;
    o.zero = 1'b1; o.wben = 1'b1; o.src = rd_en ? 2'd3 : 2'd1; o.pcsrc = 2'd2; o.rd = 5'd5;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int k;
    logic [2:0] lsz [5];
    lsz = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    k = $urandom_range(0, 2);
    o.rd_en = (k == 0);
    o.wr_en = (k == 1);
    o.size  = o.rd_en ? lsz[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
    if (k == 2) begin
      o.addr = $urandom;
    end else begin
      o.addr = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) o.addr = o.addr & ~(32'(nbytes(o.size)) - 32'd1);
    end
    o.data  = $urandom;
    o.pc4   = $urandom;
    o.pcimm = $urandom;
    o.br    = 1'($urandom_range(0, 1));
    o.jmp   = 1'($urandom_range(0, 1));
    o.zero  = 1'($urandom_range(0, 1));
    o.wben  = 1'($urandom_range(0, 1));
    o.src   = o.rd_en ? 2'd3 : 2'($urandom_range(0, 2));
    o.pcsrc = 2'($urandom);
    o.rd    = 5'($urandom);
    return o;
  endfunction

  task automatic check_reset(input int d, input string tag);
    @(negedge clk);
    check_eq({tag, " stall"}, 32'(o_stall[d]), 32'd0);
    check_eq({tag, " we"}, 32'(o_we[d]), 32'd0);
    check_eq({tag, " en"}, 32'(o_en[d]), 32'd0);
    check_eq({tag, " wb_en"}, 32'(o_wben[d]), 32'd0);
    check_eq({tag, " misaligned"}, 32'(o_mis[d]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    op_t o;
    for (int d = 0; d < 2; d++) for (int a = 0; a < 512; a++) ref_b[d][a] = '0;

    // Reset with an aligned store and a misaligned load presented.
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1;
      drive(d, mk(1'b0, 1'b1, 3'b010, 32'h40, 32'h1234_5678));
    end
    @(posedge clk);
    #1;
    check_reset(0, "rst0 store");
    check_reset(1, "rst1 store");
    for (int d = 0; d < 2; d++) drive(d, mk(1'b1, 1'b0, 3'b001, 32'h101, 32'h0));
    check_reset(0, "rst0 misaligned");
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;

    // Directed sequence at LATENCY=1.
    run_op(0, mk(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF));
    run_op(0, mk(1'b1, 1'b0, 3'b010, 32'h100, 32'h0));
    run_op(0, mk(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_0080));
    run_op(0, mk(1'b1, 1'b0, 3'b000, 32'h103, 32'h0));
    run_op(0, mk(1'b1, 1'b0, 3'b100, 32'h103, 32'h0));
    run_op(0, mk(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_8001));
    run_op(0, mk(1'b1, 1'b0, 3'b001, 32'h102, 32'h0));
    run_op(0, mk(1'b1, 1'b0, 3'b101, 32'h102, 32'h0));
    run_op(0, mk(1'b1, 1'b0, 3'b001, 32'h101, 32'h0));
    run_op(0, mk(1'b0, 1'b1, 3'b010, 32'h106, 32'hFFFF_FFFF));
    o = mk(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    o.br = 1'b1; o.zero = 1'b0; o.pcsrc = 2'd3; o.pcimm = 32'h200;
    run_op(0, o);
    o.br = 1'b0; o.jmp = 1'b1; o.zero = 1'b1;
    run_op(0, o);

    // LATENCY=4: full load, then reset in the middle of another.
    run_op(1, mk(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D));
    run_op(1, mk(1'b1, 1'b0, 3'b010, 32'h40, 32'h0));
    drive(1, mk(1'b1, 1'b0, 3'b010, 32'h40, 32'h0));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq($sformatf("pre-reset stall c%0d", c), 32'(o_stall[1]), 32'd1);
      @(posedge clk);
      #1;
    end
    rst_s[1] = 1'b1;
    for (int a = 0; a < 512; a++) ref_b[1][a] = '0;
    check_reset(1, "midrst load");
    drive(1, mk(1'b0, 1'b1, 3'b001, 32'h101, 32'h0));
    check_reset(1, "midrst misaligned");
    rst_s[1] = 1'b0;
    run_op(1, mk(1'b1, 1'b0, 3'b010, 32'h40, 32'h0));
    run_op(1, mk(1'b0, 1'b1, 3'b000, 32'h41, 32'h0000_00A5));
    run_op(1, mk(1'b1, 1'b0, 3'b000, 32'h41, 32'h0));

    // Randomized traffic on both latencies.
    for (int i = 0; i < 150; i++) run_op(0, rand_op());
    for (int i = 0; i < 120; i++) run_op(1, rand_op());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
